// File: rtl/learning_neuron.sv
// -----------------------------------------------------------------------------
// learning_neuron: single trainable threshold neuron (perceptron) with an
// output-layer error generator and per-input back-propagated error terms.
//
// Ports
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   in           : N signed Q(W-F).F inputs
//   enable       : per-input enable mask
//   rate         : learning rate
//   use_target   : 1 = output neuron (err = target - out), 0 = hidden (back_in)
//   target       : expected output
//   back_in      : error term from the downstream layer
//   learn_en     : enables weight and bias update
//   out          : registered activation, 0 or 1.0
//   back_out     : per-input back-propagated error (combinational)
//   err          : current error term (combinational from registered state)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// learning_neuron_lane: one input lane. Holds the weight, the registered input
// and enable that produced the current output, and computes the lane's product
// term, weight update and back-propagated error.
//
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   x, enable  : live input element and its enable (used for the product)
//   learn_en   : update enable
//   d          : shared step factor sat((rate*err)>>>F)
//   err        : shared error term
//   p          : masked product term for the sum
//   back_out   : masked back-propagated error using the pre-update weight
// -----------------------------------------------------------------------------
module learning_neuron_lane #(
   parameter int W = 16,
   parameter int F = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] x,
   input  logic         enable,
   input  logic         learn_en,
   input  logic [W-1:0] d,
   input  logic [W-1:0] err,
   output logic [W-1:0] p,
   output logic [W-1:0] back_out
);

   localparam logic signed [2*W:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

   function automatic logic [W-1:0] sat_w(input logic signed [2*W:0] v);
      if (v > SAT_MAX)      sat_w = SAT_MAX[W-1:0];
      else if (v < SAT_MIN) sat_w = SAT_MIN[W-1:0];
      else                  sat_w = v[W-1:0];
   endfunction

   // Sign-extend to 2W so an unsigned-context multiply still yields the
   // correct low 2W bits of the signed product.
   function automatic logic [2*W-1:0] ext2(input logic [W-1:0] v);
      ext2 = {{W{v[W-1]}}, v};
   endfunction

   logic [W-1:0]          w;
   logic [W-1:0]          x_reg;
   logic                  en_reg;

   logic signed [2*W-1:0] prod_xw, prod_dx, prod_ew;
   logic signed [2*W-1:0] sh_xw, sh_dx, sh_ew;
   logic [W-1:0]          upd;
   logic signed [2*W:0]   wsum;

   assign prod_xw = ext2(x) * ext2(w);
   assign prod_dx = ext2(d) * ext2(x_reg);
   assign prod_ew = ext2(err) * ext2(w);

   assign sh_xw = prod_xw >>> F;
   assign sh_dx = prod_dx >>> F;
   assign sh_ew = prod_ew >>> F;

   assign p        = enable ? sat_w({sh_xw[2*W-1], sh_xw}) : '0;
   assign back_out = en_reg ? sat_w({sh_ew[2*W-1], sh_ew}) : '0;

   assign upd  = sat_w({sh_dx[2*W-1], sh_dx});
   assign wsum = $signed({{(W+1){w[W-1]}}, w}) + $signed({{(W+1){upd[W-1]}}, upd});

   // The update uses en_reg/x_reg from the previous edge, i.e. the sample
   // that produced the output err was formed from.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w      <= '0;
         x_reg  <= '0;
         en_reg <= 1'b0;
      end else begin
         x_reg  <= x;
         en_reg <= enable;
         if (learn_en && en_reg) w <= sat_w(wsum);
      end
   end

endmodule

module learning_neuron #(
   parameter int N = 32,
   parameter int W = 16,
   parameter int F = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0][W-1:0] in,
   input  logic [N-1:0]        enable,
   input  logic [W-1:0]        rate,
   input  logic                use_target,
   input  logic [W-1:0]        target,
   input  logic [W-1:0]        back_in,
   input  logic                learn_en,
   output logic [W-1:0]        out,
   output logic [N-1:0][W-1:0] back_out,
   output logic [W-1:0]        err
);

   // Accumulator wide enough for N saturated products plus bias.
   localparam int SW = W + $clog2(N + 1);

   localparam logic signed [2*W:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
   localparam logic [W-1:0]        ONE     = {{(W-1){1'b0}}, 1'b1} << F;

   function automatic logic [W-1:0] sat_w(input logic signed [2*W:0] v);
      if (v > SAT_MAX)      sat_w = SAT_MAX[W-1:0];
      else if (v < SAT_MIN) sat_w = SAT_MIN[W-1:0];
      else                  sat_w = v[W-1:0];
   endfunction

   function automatic logic [2*W-1:0] ext2(input logic [W-1:0] v);
      ext2 = {{W{v[W-1]}}, v};
   endfunction

   logic [N-1:0][W-1:0]   p;
   logic [W-1:0]          bias;
   logic [W-1:0]          d;
   logic signed [SW-1:0]  acc;
   logic                  pos;
   logic signed [2*W:0]   diff;
   logic signed [2*W-1:0] prod_re, sh_re;
   logic signed [2*W:0]   bsum;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         learning_neuron_lane #(.W(W), .F(F)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .x        (in[gi]),
            .enable   (enable[gi]),
            .learn_en (learn_en),
            .d        (d),
            .err      (err),
            .p        (p[gi]),
            .back_out (back_out[gi])
         );
      end
   endgenerate

   // Bias acts as an always-enabled input of 1.0, so it enters the sum as-is.
   always_comb begin
      acc = {{(SW-W){bias[W-1]}}, bias};
      for (int i = 0; i < N; i++) acc = acc + {{(SW-W){p[i][W-1]}}, p[i]};
   end

   // Strictly positive: s = 0 yields 0.
   assign pos = !acc[SW-1] && (acc != '0);

   // err depends only on registered out and the error inputs, so a hidden
   // layer's back_in can be fed combinationally from downstream back_out.
   assign diff = $signed({{(W+1){target[W-1]}}, target}) - $signed({{(W+1){out[W-1]}}, out});
   assign err  = use_target ? sat_w(diff) : back_in;

   assign prod_re = ext2(rate) * ext2(err);
   assign sh_re   = prod_re >>> F;
   assign d       = sat_w({sh_re[2*W-1], sh_re});

   assign bsum = $signed({{(W+1){bias[W-1]}}, bias}) + $signed({{(W+1){d[W-1]}}, d});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out  <= '0;
         bias <= '0;
      end else begin
         out <= pos ? ONE : '0;
         if (learn_en) bias <= sat_w(bsum);
      end
   end

endmodule

// File: tb/tb_learning_neuron.sv
module tb_learning_neuron;

   localparam int N = 4;
   localparam int W = 16;
   localparam int F = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0][W-1:0] in_v;
   logic [N-1:0]        enable;
   logic [W-1:0]        rate;
   logic                use_target;
   logic [W-1:0]        target;
   logic [W-1:0]        back_in;
   logic                learn_en;
   logic [W-1:0]        out;
   logic [N-1:0][W-1:0] back_out;
   logic [W-1:0]        err;

   int checks = 0;
   int errors = 0;

   learning_neuron #(.N(N), .W(W), .F(F)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in_v),
      .enable     (enable),
      .rate       (rate),
      .use_target (use_target),
      .target     (target),
      .back_in    (back_in),
      .learn_en   (learn_en),
      .out        (out),
      .back_out   (back_out),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the edge; comb checks follow after #1.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit prev_and;
      int c;

      // Reset with arbitrary inputs and learning requested.
      rst_n      = 1'b0;
      for (int i = 0; i < N; i++) in_v[i] = W'($urandom);
      enable     = '1;
      rate       = 16'd256;
      use_target = 1'b1;
      target     = 16'd256;
      back_in    = 16'h1234;
      learn_en   = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_out", $signed(out), 0);
      chk("rst_err", $signed(err), 256);
      for (int i = 0; i < N; i++) chk($sformatf("rst_bo%0d", i), $signed(back_out[i]), 0);

      // Single learn step.
      rst_n    = 1'b1;
      in_v     = '0;
      in_v[0]  = 16'd256;
      in_v[1]  = 16'd256;
      enable   = 4'b0011;
      learn_en = 1'b0;
      tick();                                   // edge A
      #1;
      chk("ls_outA", $signed(out), 0);
      chk("ls_errA", $signed(err), 256);
      learn_en = 1'b1;
      tick();                                   // edge B: w0=w1=bias=256
      #1;
      chk("ls_outB", $signed(out), 0);
      learn_en   = 1'b0;
      use_target = 1'b0;
      back_in    = 16'd256;                     // err=1.0 exposes weights on back_out
      #1;
      chk("ls_w0", $signed(back_out[0]), 256);
      chk("ls_w1", $signed(back_out[1]), 256);
      chk("ls_bo2", $signed(back_out[2]), 0);
      in_v = '0;
      tick();                                   // edge C: s = bias
      #1;
      chk("ls_outC", $signed(out), 256);

      // Disabled inputs: large negative in0 and in2 masked off.
      in_v       = '0;
      in_v[0]    = 16'h8001;
      in_v[2]    = 16'd256;
      enable     = 4'b0010;
      learn_en   = 1'b1;
      tick();                                   // edge D, bias 512
      #1;
      chk("dis_outD", $signed(out), 256);
      tick();                                   // edge E, bias 768
      tick();                                   // edge F, bias 1024
      #1;
      chk("dis_bo0", $signed(back_out[0]), 0);
      chk("dis_bo2", $signed(back_out[2]), 0);
      chk("dis_w1", $signed(back_out[1]), 256);
      enable   = 4'b0101;
      learn_en = 1'b0;
      tick();                                   // edge G: p0=-32767 now included
      #1;
      chk("dis_outG", $signed(out), 0);
      chk("dis_w0", $signed(back_out[0]), 256);
      chk("dis_w2", $signed(back_out[2]), 0);

      // Back-propagation with learning off.
      in_v   = '0;
      enable = 4'b0001;
      tick();                                   // edge H: out=1.0
      use_target = 1'b1;
      target     = 16'd0;
      #1;
      chk("bp_out", $signed(out), 256);
      chk("bp_err", $signed(err), -256);
      chk("bp_bo0", $signed(back_out[0]), -256);
      chk("bp_bo1", $signed(back_out[1]), 0);
      tick();                                   // edge I
      #1;
      chk("bp_bo0_hold", $signed(back_out[0]), -256);
      chk("bp_out_hold", $signed(out), 256);

      // Saturation of weight, bias and target-out.
      rst_n = 1'b0;
      tick();
      rst_n      = 1'b1;
      enable     = 4'b0001;
      in_v       = '0;
      in_v[0]    = 16'h7FFF;
      rate       = 16'h7FFF;
      use_target = 1'b0;
      back_in    = 16'h7FFF;
      learn_en   = 1'b1;
      repeat (4) tick();
      learn_en = 1'b0;
      back_in  = 16'd256;
      #1;
      chk("sat_w0", $signed(back_out[0]), 32767);
      chk("sat_out", $signed(out), 256);
      use_target = 1'b1;
      target     = 16'h8000;
      #1;
      chk("sat_err", $signed(err), -32768);

      // Reset in the middle of training state.
      rst_n    = 1'b0;
      learn_en = 1'b1;
      target   = 16'd256;
      rate     = 16'd256;
      tick();
      #1;
      chk("mrst_out", $signed(out), 0);
      chk("mrst_err", $signed(err), 256);
      chk("mrst_bo0", $signed(back_out[0]), 0);

      // AND training: target lags the input by one cycle so it lines up with out.
      rst_n    = 1'b1;
      enable   = 4'b0011;
      learn_en = 1'b1;
      in_v     = '0;
      prev_and = 1'b0;
      for (int k = 0; k < 64; k++) begin
         c       = k % 4;
         in_v[0] = c[0] ? 16'd256 : 16'd0;
         in_v[1] = c[1] ? 16'd256 : 16'd0;
         target  = prev_and ? 16'd256 : 16'd0;
         tick();
         prev_and = (c == 3);
         if (k >= 56) begin
            target = prev_and ? 16'd256 : 16'd0;
            #1;
            chk($sformatf("and_out%0d", k), $signed(out), prev_and ? 256 : 0);
            chk($sformatf("and_err%0d", k), $signed(err), 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
